// File: rtl/arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : arb_pkg
// Purpose  : Shared constants and FSM state type for the 8-way round-robin arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package arb_pkg;

  localparam int N_REQ            = 8;
  localparam int IDX_W            = 3;
  localparam int MAX_HOLD_DEFAULT = 16;
  localparam int CNT_W_DEFAULT    = 5;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Purpose  : Combinational rotating priority encoder; first set request at or after ptr.
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] win_idx,
  output logic             win_valid
);

  logic [2*N_REQ-1:0] w_dbl;
  logic [N_REQ-1:0]   w_rot;
  logic               w_found;

  // Doubling the vector turns the modular search into a plain slice.
  assign w_dbl = {req, req};
  assign w_rot = w_dbl[ptr +: N_REQ];

  always_comb begin
    win_valid = |req;
    win_idx   = '0;
    w_found   = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!w_found && w_rot[i]) begin
        w_found = 1'b1;
        win_idx = ptr + IDX_W'(i);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/rr_arbiter_8.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter_8
// Purpose  : 8-requester round-robin arbiter with registered one-hot grant and hold timeout.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter_8
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = MAX_HOLD_DEFAULT,
  parameter int CNT_W    = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_valid,
  output logic             preempt
);

  state_e             state_q,       state_d;
  logic [IDX_W-1:0]   ptr_q,         ptr_d;
  logic [CNT_W-1:0]   hold_cnt_q,    hold_cnt_d;
  logic [N_REQ-1:0]   grant_q,       grant_d;
  logic [IDX_W-1:0]   grant_idx_q,   grant_idx_d;
  logic               grant_valid_q, grant_valid_d;
  logic               preempt_q,     preempt_d;

  logic [IDX_W-1:0]   w_win_idx;
  logic               w_win_valid;
  logic               w_timeout;

  rr_pick u_pick (
    .req       (req),
    .ptr       (ptr_q),
    .win_idx   (w_win_idx),
    .win_valid (w_win_valid)
  );

  generate
    if (MAX_HOLD != 0) begin : g_timeout_en
      assign w_timeout = (hold_cnt_q == CNT_W'(MAX_HOLD - 1));
    end else begin : g_timeout_dis
      assign w_timeout = 1'b0;
    end
  endgenerate

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    hold_cnt_d    = hold_cnt_q;
    grant_d       = grant_q;
    grant_idx_d   = grant_idx_q;
    grant_valid_d = grant_valid_q;
    preempt_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (w_win_valid) begin
          grant_d       = N_REQ'(1) << w_win_idx;
          grant_idx_d   = w_win_idx;
          grant_valid_d = 1'b1;
          // Pointer moves at grant time so a preempted holder ranks last next round.
          ptr_d         = w_win_idx + IDX_W'(1);
          hold_cnt_d    = '0;
          state_d       = GRANT;
        end
      end
      GRANT: begin
        if (!req[grant_idx_q] || w_timeout) begin
          grant_d       = '0;
          grant_idx_d   = '0;
          grant_valid_d = 1'b0;
          hold_cnt_d    = '0;
          preempt_d     = req[grant_idx_q];
          state_d       = IDLE;
        end else begin
          hold_cnt_d    = hold_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      ptr_q         <= '0;
      hold_cnt_q    <= '0;
      grant_q       <= '0;
      grant_idx_q   <= '0;
      grant_valid_q <= 1'b0;
      preempt_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      hold_cnt_q    <= hold_cnt_d;
      grant_q       <= grant_d;
      grant_idx_q   <= grant_idx_d;
      grant_valid_q <= grant_valid_d;
      preempt_q     <= preempt_d;
    end
  end

  assign grant       = grant_q;
  assign grant_idx   = grant_idx_q;
  assign grant_valid = grant_valid_q;
  assign preempt     = preempt_q;

endmodule
`default_nettype wire

// File: doc/rr_arbiter_8.md
Name: rr_arbiter_8

Overview:
- Round-robin arbiter that shares one downstream resource (e.g. the 8-to-3 encoder datapath or bus slot) among 8 requesters.
- Each requester raises a request line and holds it for as long as it needs the resource.
- The arbiter issues exactly one registered grant at a time, as a one-hot vector plus a 3-bit index.
- Rotating priority and an optional hold timeout give fairness and prevent starvation.

Parameters:
- N_REQ, 8, number of requesters; fixed at 8 for this revision.
- IDX_W, 3, width of the grant index, log2(N_REQ).
- MAX_HOLD, 16, maximum consecutive grant cycles before forced release; 0 disables the timeout.
- CNT_W, 5, width of the hold counter; must hold MAX_HOLD.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- req  input  8  request lines; bit i belongs to requester i; level-sensitive.
- grant  output  8  one-hot grant, registered; all zero when idle.
- grant_idx  output  3  binary index of the granted requester, registered; 0 when idle.
- grant_valid  output  1  high while any grant is active; equals OR of grant.
- preempt  output  1  one-cycle pulse when a grant is revoked by timeout.

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst. All state is updated on the rising edge of clk.
- Reset values: grant=0, grant_idx=0, grant_valid=0, preempt=0, state=IDLE, ptr=0, hold_cnt=0.
- Reset mid-grant drops the grant on that same edge. No preempt pulse is issued.
- State IDLE:
  - If req != 0 at an edge, pick winner w = first set bit searching ptr, ptr+1, ... ptr+7, all mod 8.
  - At that edge: grant=1<<w, grant_idx=w, grant_valid=1, ptr=(w+1) mod 8, hold_cnt=0, go to GRANT.
  - Latency: req sampled high at edge N gives grant visible after edge N.
  - If req == 0, stay in IDLE with outputs at their idle values.
- State GRANT:
  - If req[grant_idx] is 0 at an edge (normal release): clear grant, go to IDLE.
  - After a release there is always exactly one idle cycle before the next grant. There is no back-to-back regrant.
  - Else if MAX_HOLD != 0 and hold_cnt == MAX_HOLD-1: clear grant, assert preempt for one cycle, go to IDLE.
  - Else: hold_cnt increments; grant is unchanged.
- Requests from other requesters during GRANT are ignored. They are not latched and are re-evaluated in IDLE.
- ptr wrap-around: a winner of 7 sets ptr=0.
- The pointer advances at grant time, not at release. A preempted requester that is still requesting therefore has lowest priority at the next arbitration.
- A requester that is alone still wins again after preemption, following the 1-cycle idle gap.
- All requests high: grants rotate 0,1,2,...,7,0 in successive arbitrations.
- grant is always one-hot or zero. grant_idx always matches grant.
- Widths: ptr, winner and grant_idx are IDX_W bits, with natural mod-8 wrap. hold_cnt is CNT_W bits and never exceeds MAX_HOLD-1.

Decomposition:
- Package arb_pkg holds:
  - N_REQ and IDX_W constants;
  - state typedef {IDLE, GRANT};
  - a default MAX_HOLD constant.
- Sub-module rr_pick is the natural split. It is a combinational rotating priority encoder.
  - Inputs: req[7:0], ptr[2:0].
  - Outputs: win_idx[2:0], win_valid.
  - It contains the 8-to-3 encoding logic.
  - It can be unit-tested exhaustively: 256 req values by 8 ptr values.
- The top level holds the FSM, the pointer, the hold counter and the output registers.

Test Plan:
- Reset then single request: rst high 2 cycles, then req=8'b0000_0100 held. Expect grant=8'b0000_0100, grant_idx=2 one edge after req is sampled, and ptr becomes 3. Drop req: grant=0 next edge.
- Round robin: req=8'hFF held permanently, MAX_HOLD=4. Expect grant_idx sequence 0,1,2,...,7,0. Each grant lasts 4 cycles, then a preempt pulse, then 1 idle cycle.
- Pointer skip and wrap: ptr=6 after granting 5, then req=8'b0000_0011. Expect winner 0 (search 6,7,0), then ptr=1. Next arbitration with the same req: winner 1.
- Non-preemption by others: requester 3 granted; assert req[7] mid-grant. Expect grant stays 8'b0000_1000 until req[3] drops. Requester 7 is granted after the idle cycle.
- Timeout disabled: MAX_HOLD=0, req=8'b1000_0000 held 100 cycles. Expect grant_idx=7 continuously and preempt never high.
- Reset mid-operation: rst pulsed while grant_idx=5. Expect all outputs zero on that edge and no preempt pulse. With req=8'hFF afterward, the first grant is index 0.
